// File: rtl/cu_pkg.sv
// Shared definitions for the datapath control unit: FSM states, instruction
// opcodes, ALU operation codes and the datapath strobe bundle.
package cu_pkg;

  localparam int OPC_W = 5;

  typedef enum logic [3:0] {
    RESET_ST, T0, T1, T2, T3, T4, T5, T6, T7, STOPPED, HALTED
  } state_e;

  localparam logic [OPC_W-1:0] OP_LD   = 5'h00;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'h01;
  localparam logic [OPC_W-1:0] OP_ST   = 5'h02;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'h03;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'h04;
  localparam logic [OPC_W-1:0] OP_AND  = 5'h05;
  localparam logic [OPC_W-1:0] OP_OR   = 5'h06;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'h07;
  localparam logic [OPC_W-1:0] OP_SHRA = 5'h08;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'h09;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'h0A;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'h0B;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'h0C;
  localparam logic [OPC_W-1:0] OP_ANDI = 5'h0D;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'h0E;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'h0F;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'h10;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'h11;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'h12;
  localparam logic [OPC_W-1:0] OP_IN   = 5'h13;
  localparam logic [OPC_W-1:0] OP_OUT  = 5'h14;
  localparam logic [OPC_W-1:0] OP_MFHI = 5'h15;
  localparam logic [OPC_W-1:0] OP_MFLO = 5'h16;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'h1A;
  localparam logic [OPC_W-1:0] OP_HALT = 5'h1B;

  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_MUL  = 5'd3;
  localparam logic [4:0] ALU_DIV  = 5'd4;
  localparam logic [4:0] ALU_SHR  = 5'd5;
  localparam logic [4:0] ALU_SHL  = 5'd6;
  localparam logic [4:0] ALU_SHRA = 5'd7;
  localparam logic [4:0] ALU_ROR  = 5'd8;
  localparam logic [4:0] ALU_ROL  = 5'd9;
  localparam logic [4:0] ALU_AND  = 5'd10;
  localparam logic [4:0] ALU_OR   = 5'd11;
  localparam logic [4:0] ALU_NEG  = 5'd12;
  localparam logic [4:0] ALU_NOT  = 5'd15;

  typedef struct packed {
    logic read;      logic write;     logic BAout;     logic Rin;
    logic Rout;      logic Gra;       logic Grb;       logic Grc;
    logic CONN_in;   logic MARin;     logic MDRin;     logic HIin;
    logic LOin;      logic Yin;       logic Zin;       logic PCin;
    logic IRin;      logic incPC;     logic InPortIn;  logic OutPortIn;
    logic HIout;     logic LOout;     logic ZHighOut;  logic ZLowOut;
    logic MDRout;    logic PCout;     logic InPortOut; logic Cout;
  } strobe_t;

  function automatic logic [4:0] alu_of(input logic [OPC_W-1:0] op);
    case (op)
      OP_ADD, OP_ADDI: alu_of = ALU_ADD;
      OP_SUB:          alu_of = ALU_SUB;
      OP_AND, OP_ANDI: alu_of = ALU_AND;
      OP_OR, OP_ORI:   alu_of = ALU_OR;
      OP_SHR:          alu_of = ALU_SHR;
      OP_SHRA:         alu_of = ALU_SHRA;
      OP_SHL:          alu_of = ALU_SHL;
      OP_ROR:          alu_of = ALU_ROR;
      OP_ROL:          alu_of = ALU_ROL;
      OP_MUL:          alu_of = ALU_MUL;
      OP_DIV:          alu_of = ALU_DIV;
      OP_NEG:          alu_of = ALU_NEG;
      OP_NOT:          alu_of = ALU_NOT;
      default:         alu_of = 5'd0;
    endcase
  endfunction

  // Final execute state of each opcode; the cycle after it is the T0 boundary.
  function automatic state_e last_state(input logic [OPC_W-1:0] op);
    case (op)
      OP_LD, OP_ST:                        last_state = T7;
      OP_MUL, OP_DIV:                      last_state = T6;
      OP_NEG, OP_NOT:                      last_state = T4;
      OP_IN, OP_OUT, OP_MFHI, OP_MFLO,
      OP_NOP, OP_HALT:                     last_state = T3;
      default: last_state = (op >= OP_LDI && op <= OP_ORI) ? T5 : T3;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [OPC_W-1:0] op);
    is_illegal = (op >= 5'h17 && op <= 5'h19) || (op >= 5'h1C);
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational strobe/ALU decode from FSM state and opcode. Strobes that are
// not listed for a state stay low; CONN_in and InPortIn are never driven high.
module cu_decode
  import cu_pkg::*;
#(
  parameter int ALU_OP_W = 5
) (
  input  state_e                state_i,
  input  logic [OPC_W-1:0]      opcode_i,
  output strobe_t               strb_o,
  output logic [ALU_OP_W-1:0]   alu_op_o,
  output logic                  illegal_o
);

  always_comb begin
    strb_o    = '0;
    alu_op_o  = '0;
    illegal_o = 1'b0;
    case (state_i)
      T0: begin
        strb_o.PCout = 1'b1; strb_o.MARin = 1'b1; strb_o.incPC = 1'b1; strb_o.Zin = 1'b1;
      end
      T1: begin
        strb_o.ZLowOut = 1'b1; strb_o.PCin = 1'b1; strb_o.read = 1'b1; strb_o.MDRin = 1'b1;
      end
      T2: begin
        strb_o.MDRout = 1'b1; strb_o.IRin = 1'b1;
      end
      T3, T4, T5, T6, T7: begin
        if (opcode_i == OP_LD || opcode_i == OP_LDI || opcode_i == OP_ST) begin
          case (state_i)
            T3: begin strb_o.Grb = 1'b1; strb_o.BAout = 1'b1; strb_o.Yin = 1'b1; end
            T4: begin
              strb_o.Cout = 1'b1; strb_o.Zin = 1'b1; alu_op_o = ALU_OP_W'(ALU_ADD);
            end
            T5: begin
              strb_o.ZLowOut = 1'b1;
              if (opcode_i == OP_LDI) begin strb_o.Gra = 1'b1; strb_o.Rin = 1'b1; end
              else strb_o.MARin = 1'b1;
            end
            T6: begin
              strb_o.MDRin = 1'b1;
              if (opcode_i == OP_ST) begin strb_o.Gra = 1'b1; strb_o.Rout = 1'b1; end
              else strb_o.read = 1'b1;
            end
            T7: begin
              if (opcode_i == OP_ST) strb_o.write = 1'b1;
              else begin strb_o.MDRout = 1'b1; strb_o.Gra = 1'b1; strb_o.Rin = 1'b1; end
            end
            default: ;
          endcase
        end else if (opcode_i >= OP_ADD && opcode_i <= OP_ORI) begin
          // Immediate forms take operand B from the constant path instead of Rc.
          case (state_i)
            T3: begin strb_o.Grb = 1'b1; strb_o.Rout = 1'b1; strb_o.Yin = 1'b1; end
            T4: begin
              strb_o.Zin = 1'b1; alu_op_o = ALU_OP_W'(alu_of(opcode_i));
              if (opcode_i >= OP_ADDI) strb_o.Cout = 1'b1;
              else begin strb_o.Grc = 1'b1; strb_o.Rout = 1'b1; end
            end
            T5: begin strb_o.ZLowOut = 1'b1; strb_o.Gra = 1'b1; strb_o.Rin = 1'b1; end
            default: ;
          endcase
        end else if (opcode_i == OP_MUL || opcode_i == OP_DIV) begin
          case (state_i)
            T3: begin strb_o.Gra = 1'b1; strb_o.Rout = 1'b1; strb_o.Yin = 1'b1; end
            T4: begin
              strb_o.Grb = 1'b1; strb_o.Rout = 1'b1; strb_o.Zin = 1'b1;
              alu_op_o = ALU_OP_W'(alu_of(opcode_i));
            end
            T5: begin strb_o.ZLowOut = 1'b1; strb_o.LOin = 1'b1; end
            T6: begin strb_o.ZHighOut = 1'b1; strb_o.HIin = 1'b1; end
            default: ;
          endcase
        end else if (opcode_i == OP_NEG || opcode_i == OP_NOT) begin
          case (state_i)
            T3: begin
              strb_o.Grb = 1'b1; strb_o.Rout = 1'b1; strb_o.Zin = 1'b1;
              alu_op_o = ALU_OP_W'(alu_of(opcode_i));
            end
            T4: begin strb_o.ZLowOut = 1'b1; strb_o.Gra = 1'b1; strb_o.Rin = 1'b1; end
            default: ;
          endcase
        end else if (state_i == T3) begin
          case (opcode_i)
            OP_IN:   begin strb_o.InPortOut = 1'b1; strb_o.Gra = 1'b1; strb_o.Rin = 1'b1; end
            OP_OUT:  begin strb_o.Gra = 1'b1; strb_o.Rout = 1'b1; strb_o.OutPortIn = 1'b1; end
            OP_MFHI: begin strb_o.HIout = 1'b1; strb_o.Gra = 1'b1; strb_o.Rin = 1'b1; end
            OP_MFLO: begin strb_o.LOout = 1'b1; strb_o.Gra = 1'b1; strb_o.Rin = 1'b1; end
            default: illegal_o = is_illegal(opcode_i);
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/datapath_ctrl_unit.sv
// Hardwired fetch/execute sequencer for the 32-bit bus datapath.
// Optional CU_INSTR_COUNT_EN adds a retired-instruction counter output.
module datapath_ctrl_unit
  import cu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ALU_OP_W = 5
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [DATA_W-1:0]   ir,
  input  logic                stop,
  output logic                run,
  output logic                illegal,
  output logic                read,
  output logic                write,
  output logic                BAout,
  output logic                Rin,
  output logic                Rout,
  output logic                Gra,
  output logic                Grb,
  output logic                Grc,
  output logic                CONN_in,
  output logic                MARin,
  output logic                MDRin,
  output logic                HIin,
  output logic                LOin,
  output logic                Yin,
  output logic                Zin,
  output logic                PCin,
  output logic                IRin,
  output logic                incPC,
  output logic                InPortIn,
  output logic                OutPortIn,
  output logic                HIout,
  output logic                LOout,
  output logic                ZHighOut,
  output logic                ZLowOut,
  output logic                MDRout,
  output logic                PCout,
  output logic                InPortOut,
  output logic                Cout,
  output logic [ALU_OP_W-1:0] alu_op
`ifdef CU_INSTR_COUNT_EN
 ,output logic [31:0]         instr_count
`endif
);

  state_e           state_q, state_d;
  logic [OPC_W-1:0] opcode;
  logic             unused_ir_bits;
  logic             in_exec;
  strobe_t          strb;

  assign opcode         = ir[DATA_W-1 -: OPC_W];
  assign unused_ir_bits = ^ir[DATA_W-OPC_W-1:0];
  assign in_exec        = (state_q == T3) || (state_q == T4) || (state_q == T5) ||
                          (state_q == T6) || (state_q == T7);

  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET_ST: state_d = T0;
      T0:       state_d = stop ? STOPPED : T1;
      T1:       state_d = T2;
      T2:       state_d = T3;
      T3, T4, T5, T6, T7: begin
        if (state_q == T3 && opcode == OP_HALT) state_d = HALTED;
        else if (state_q == last_state(opcode)) state_d = T0;
        else state_d = state_e'(state_q + 4'd1);
      end
      STOPPED:  state_d = stop ? STOPPED : T0;
      HALTED:   state_d = HALTED;
      default:  state_d = RESET_ST;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= RESET_ST;
    else     state_q <= state_d;
  end

`ifdef CU_INSTR_COUNT_EN
  logic [31:0] count_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr)                             count_q <= '0;
    else if (in_exec && state_d == T0)   count_q <= count_q + 32'd1;
  end

  assign instr_count = count_q;
`endif

  cu_decode #(.ALU_OP_W(ALU_OP_W)) u_decode (
    .state_i   (state_q),
    .opcode_i  (opcode),
    .strb_o    (strb),
    .alu_op_o  (alu_op),
    .illegal_o (illegal)
  );

  assign run = in_exec || state_q == T0 || state_q == T1 || state_q == T2;

  assign read      = strb.read;
  assign write     = strb.write;
  assign BAout     = strb.BAout;
  assign Rin       = strb.Rin;
  assign Rout      = strb.Rout;
  assign Gra       = strb.Gra;
  assign Grb       = strb.Grb;
  assign Grc       = strb.Grc;
  assign CONN_in   = strb.CONN_in;
  assign MARin     = strb.MARin;
  assign MDRin     = strb.MDRin;
  assign HIin      = strb.HIin;
  assign LOin      = strb.LOin;
  assign Yin       = strb.Yin;
  assign Zin       = strb.Zin;
  assign PCin      = strb.PCin;
  assign IRin      = strb.IRin;
  assign incPC     = strb.incPC;
  assign InPortIn  = strb.InPortIn;
  assign OutPortIn = strb.OutPortIn;
  assign HIout     = strb.HIout;
  assign LOout     = strb.LOout;
  assign ZHighOut  = strb.ZHighOut;
  assign ZLowOut   = strb.ZLowOut;
  assign MDRout    = strb.MDRout;
  assign PCout     = strb.PCout;
  assign InPortOut = strb.InPortOut;
  assign Cout      = strb.Cout;

endmodule

// File: tb/tb_datapath_ctrl_unit.sv
// Self-checking bench for datapath_ctrl_unit: per-instruction expected strobe
// sequences are built from the opcode table and compared cycle by cycle.
module tb_datapath_ctrl_unit;

  localparam logic [27:0] M_READ = 28'd1 << 0,  M_WRITE = 28'd1 << 1,  M_BAOUT = 28'd1 << 2;
  localparam logic [27:0] M_RIN  = 28'd1 << 3,  M_ROUT  = 28'd1 << 4,  M_GRA   = 28'd1 << 5;
  localparam logic [27:0] M_GRB  = 28'd1 << 6,  M_GRC   = 28'd1 << 7,  M_MARIN = 28'd1 << 9;
  localparam logic [27:0] M_MDRIN = 28'd1 << 10, M_HIIN = 28'd1 << 11, M_LOIN  = 28'd1 << 12;
  localparam logic [27:0] M_YIN  = 28'd1 << 13, M_ZIN   = 28'd1 << 14, M_PCIN  = 28'd1 << 15;
  localparam logic [27:0] M_IRIN = 28'd1 << 16, M_INCPC = 28'd1 << 17, M_OUTPIN = 28'd1 << 19;
  localparam logic [27:0] M_HIOUT = 28'd1 << 20, M_LOOUT = 28'd1 << 21, M_ZHI   = 28'd1 << 22;
  localparam logic [27:0] M_ZLO  = 28'd1 << 23, M_MDROUT = 28'd1 << 24, M_PCOUT = 28'd1 << 25;
  localparam logic [27:0] M_INPOUT = 28'd1 << 26, M_COUT = 28'd1 << 27;

  typedef struct packed {
    logic       run;
    logic       ill;
    logic [4:0] alu;
    logic [27:0] s;
  } step_t;

  logic clk = 1'b0, clr = 1'b1, stop = 1'b0;
  logic [31:0] ir = 32'h0;
  logic run, illegal, read, write, BAout, Rin, Rout, Gra, Grb, Grc, CONN_in, MARin, MDRin;
  logic HIin, LOin, Yin, Zin, PCin, IRin, incPC, InPortIn, OutPortIn, HIout, LOout;
  logic ZHighOut, ZLowOut, MDRout, PCout, InPortOut, Cout;
  logic [4:0] alu_op;
`ifdef CU_INSTR_COUNT_EN
  logic [31:0] instr_count;
`endif
  logic [27:0] obs;

  int checks = 0, passes = 0;
  logic [31:0] n_done = 0;
  step_t exp_q[$];

  always #5 clk = ~clk;

  datapath_ctrl_unit dut (
    .clk(clk), .clr(clr), .ir(ir), .stop(stop), .run(run), .illegal(illegal),
    .read(read), .write(write), .BAout(BAout), .Rin(Rin), .Rout(Rout), .Gra(Gra),
    .Grb(Grb), .Grc(Grc), .CONN_in(CONN_in), .MARin(MARin), .MDRin(MDRin), .HIin(HIin),
    .LOin(LOin), .Yin(Yin), .Zin(Zin), .PCin(PCin), .IRin(IRin), .incPC(incPC),
    .InPortIn(InPortIn), .OutPortIn(OutPortIn), .HIout(HIout), .LOout(LOout),
    .ZHighOut(ZHighOut), .ZLowOut(ZLowOut), .MDRout(MDRout), .PCout(PCout),
    .InPortOut(InPortOut), .Cout(Cout), .alu_op(alu_op)
`ifdef CU_INSTR_COUNT_EN
   ,.instr_count(instr_count)
`endif
  );

  assign obs = {Cout, InPortOut, PCout, MDRout, ZLowOut, ZHighOut, LOout, HIout,
                OutPortIn, InPortIn, incPC, IRin, PCin, Zin, Yin, LOin, HIin, MDRin,
                MARin, CONN_in, Grc, Grb, Gra, Rout, Rin, BAout, write, read};

  function automatic step_t mk(input logic [27:0] s, input logic [4:0] a, input logic il);
    return {1'b1, il, a, s};
  endfunction

  function automatic logic [4:0] alu_code(input logic [4:0] op);
    case (op)
      5'h03, 5'h0C: return 5'd1;
      5'h04:        return 5'd2;
      5'h05, 5'h0D: return 5'd10;
      5'h06, 5'h0E: return 5'd11;
      5'h07:        return 5'd5;
      5'h08:        return 5'd7;
      5'h09:        return 5'd6;
      5'h0A:        return 5'd8;
      5'h0B:        return 5'd9;
      5'h0F:        return 5'd3;
      5'h10:        return 5'd4;
      5'h11:        return 5'd12;
      5'h12:        return 5'd15;
      default:      return 5'd0;
    endcase
  endfunction

  function automatic void build(input logic [4:0] op);
    exp_q.delete();
    exp_q.push_back(mk(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd0, 1'b0));
    exp_q.push_back(mk(M_ZLO | M_PCIN | M_READ | M_MDRIN, 5'd0, 1'b0));
    exp_q.push_back(mk(M_MDROUT | M_IRIN, 5'd0, 1'b0));
    if (op <= 5'h02) begin
      exp_q.push_back(mk(M_GRB | M_BAOUT | M_YIN, 5'd0, 1'b0));
      exp_q.push_back(mk(M_COUT | M_ZIN, 5'd1, 1'b0));
      if (op == 5'h01) exp_q.push_back(mk(M_ZLO | M_GRA | M_RIN, 5'd0, 1'b0));
      else begin
        exp_q.push_back(mk(M_ZLO | M_MARIN, 5'd0, 1'b0));
        if (op == 5'h00) begin
          exp_q.push_back(mk(M_READ | M_MDRIN, 5'd0, 1'b0));
          exp_q.push_back(mk(M_MDROUT | M_GRA | M_RIN, 5'd0, 1'b0));
        end else begin
          exp_q.push_back(mk(M_GRA | M_ROUT | M_MDRIN, 5'd0, 1'b0));
          exp_q.push_back(mk(M_WRITE, 5'd0, 1'b0));
        end
      end
    end else if (op <= 5'h0E) begin
      exp_q.push_back(mk(M_GRB | M_ROUT | M_YIN, 5'd0, 1'b0));
      exp_q.push_back(mk(((op >= 5'h0C) ? M_COUT : (M_GRC | M_ROUT)) | M_ZIN, alu_code(op), 1'b0));
      exp_q.push_back(mk(M_ZLO | M_GRA | M_RIN, 5'd0, 1'b0));
    end else if (op <= 5'h10) begin
      exp_q.push_back(mk(M_GRA | M_ROUT | M_YIN, 5'd0, 1'b0));
      exp_q.push_back(mk(M_GRB | M_ROUT | M_ZIN, alu_code(op), 1'b0));
      exp_q.push_back(mk(M_ZLO | M_LOIN, 5'd0, 1'b0));
      exp_q.push_back(mk(M_ZHI | M_HIIN, 5'd0, 1'b0));
    end else if (op <= 5'h12) begin
      exp_q.push_back(mk(M_GRB | M_ROUT | M_ZIN, alu_code(op), 1'b0));
      exp_q.push_back(mk(M_ZLO | M_GRA | M_RIN, 5'd0, 1'b0));
    end else if (op == 5'h13) exp_q.push_back(mk(M_INPOUT | M_GRA | M_RIN, 5'd0, 1'b0));
    else if (op == 5'h14) exp_q.push_back(mk(M_GRA | M_ROUT | M_OUTPIN, 5'd0, 1'b0));
    else if (op == 5'h15) exp_q.push_back(mk(M_HIOUT | M_GRA | M_RIN, 5'd0, 1'b0));
    else if (op == 5'h16) exp_q.push_back(mk(M_LOOUT | M_GRA | M_RIN, 5'd0, 1'b0));
    else if (op == 5'h1A || op == 5'h1B) exp_q.push_back(mk(28'd0, 5'd0, 1'b0));
    else exp_q.push_back(mk(28'd0, 5'd0, 1'b1));
  endfunction

  // Called at a negedge with the DUT in T0; returns at the negedge of the next T0
  // (or right after asserting clr when abort_at is reached).
  task automatic run_instr(input logic [31:0] irv, input int stop_at, input int abort_at);
    step_t got;
    build(irv[31:27]);
    ir = irv;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k == stop_at) stop = 1'b1;
      #1;
      got = {run, illegal, alu_op, obs};
      checks++;
      if (got !== exp_q[k])
        $display("FAIL seq op=%02h step=%0d got=%h want=%h", irv[31:27], k, got, exp_q[k]);
      else passes++;
      if (k == abort_at) begin
        #2 clr = 1'b1;
        #1;
        checks++;
        if ({run, illegal, alu_op, obs} !== 35'd0)
          $display("FAIL clr_async got=%h want=0", {run, illegal, alu_op, obs});
        else passes++;
        n_done = 0;
        return;
      end
      @(negedge clk);
    end
    n_done++;
  endtask

  task automatic check_count(input string tag);
`ifdef CU_INSTR_COUNT_EN
    checks++;
    if (instr_count !== n_done) $display("FAIL count_%s got=%0d want=%0d", tag, instr_count, n_done);
    else passes++;
`endif
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({run, illegal, alu_op, obs} !== 35'd0) $display("FAIL reset got=%h want=0", {run, illegal, alu_op, obs});
    else passes++;
    check_count("reset");
    clr = 1'b0;
    #1;
    checks++;
    if ({run, obs} !== 29'd0) $display("FAIL reset_release got=%h want=0", {run, obs});
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_instr(32'h00800075, -1, -1);
    run_instr(32'h18918000, -1, -1);
    run_instr(32'h78900000, -1, -1);
    run_instr(32'hF8000000, -1, -1);
    check_count("directed");
  endtask

  task automatic test_random();
    logic [4:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'h1B) op = 5'h1A;
      run_instr({op, 27'($urandom)}, -1, -1);
    end
    check_count("random");
  endtask

  task automatic test_stop();
    run_instr(32'h18918000, 4, -1);
    #1;
    checks++;
    if ({run, illegal, alu_op, obs} !== mk(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd0, 1'b0))
      $display("FAIL stop_boundary got=%h", {run, illegal, alu_op, obs});
    else passes++;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({run, illegal, alu_op, obs} !== 35'd0)
        $display("FAIL stopped got=%h want=0", {run, illegal, alu_op, obs});
      else passes++;
      @(negedge clk);
    end
    check_count("stopped");
    stop = 1'b0;
    @(negedge clk);
    run_instr(32'h88800000, -1, -1);
  endtask

  task automatic test_clr_mid();
    run_instr(32'h10800010, -1, 6);
    check_count("clr");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({run, write, obs} !== 30'd0) $display("FAIL clr_hold got=%h want=0", {run, write, obs});
      else passes++;
    end
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    run_instr(32'h08800004, -1, -1);
  endtask

  task automatic test_halt();
    run_instr(32'hD8000000, -1, -1);
    n_done--;
    stop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) stop = 1'b0;
      #1;
      checks++;
      if ({run, illegal, alu_op, obs} !== 35'd0)
        $display("FAIL halted got=%h want=0", {run, illegal, alu_op, obs});
      else passes++;
      @(negedge clk);
    end
    check_count("halt");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stop();
    test_clr_mid();
    test_halt();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

endmodule
